// File: rtl/sb_io_pkg.sv
// Shared field encodings for the SB_IO PIN_TYPE parameter.
package sb_io_pkg;

  localparam logic [1:0] PIN_INPUT           = 2'b01;
  localparam logic [1:0] PIN_INPUT_REG       = 2'b00;
  localparam logic [1:0] PIN_INPUT_LATCH     = 2'b11;
  localparam logic [1:0] PIN_INPUT_REG_LATCH = 2'b10;

  localparam logic [1:0] OUT_DDR     = 2'b00;
  localparam logic [1:0] OUT_REG     = 2'b01;
  localparam logic [1:0] OUT_SIMPLE  = 2'b10;
  localparam logic [1:0] OUT_REG_INV = 2'b11;

  localparam logic [1:0] OE_OFF     = 2'b00;
  localparam logic [1:0] OE_ON      = 2'b01;
  localparam logic [1:0] OE_TRI     = 2'b10;
  localparam logic [1:0] OE_TRI_REG = 2'b11;

  typedef struct packed {
    logic [1:0] oe_mode;
    logic [1:0] out_mode;
    logic [1:0] in_mode;
  } pin_type_t;

endpackage

// File: rtl/sb_io_ddr_reg.sv
// Rise/fall register pair with shared clock enable and asynchronous clear.
module sb_io_ddr_reg (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_i,
  input  logic d_rise_i,
  input  logic d_fall_i,
  output logic q_rise_o,
  output logic q_fall_o
);

  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rise_q <= 1'b0;
    else if (ce_i) rise_q <= d_rise_i;
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   fall_q <= 1'b0;
    else if (ce_i) fall_q <= d_fall_i;
  end

  assign q_rise_o = rise_q;
  assign q_fall_o = fall_q;

endmodule

// File: rtl/sb_io_cell.sv
// Behavioural iCE40 programmable I/O cell: selectable input, output and
// output-enable paths around one package pin, with optional weak pull-up.
module sb_io_cell
  import sb_io_pkg::*;
#(
  parameter logic [5:0] PIN_TYPE    = 6'b000000,
  parameter bit         PULLUP      = 1'b0,
  parameter bit         NEG_TRIGGER = 1'b0,
  parameter             IO_STANDARD = "SB_LVCMOS"
) (
  input  logic clk,
  input  logic rst_n,
  inout  wire  PACKAGE_PIN,
  input  logic CLOCK_ENABLE,
  input  logic LATCH_INPUT_VALUE,
  input  logic OUTPUT_ENABLE,
  input  logic D_OUT_0,
  input  logic D_OUT_1,
  output logic D_IN_0,
  output logic D_IN_1
);

  localparam pin_type_t PT = pin_type_t'(PIN_TYPE);

  logic clk_act;
  logic pin_in;
  logic in_ce;
  logic in_q0, in_q1;
  logic out_q0, out_q1;
  logic oe_q;
  logic lat_q;
  logic din0_d;
  logic out_data_d;
  logic oe_drive_d;

  // The "rise" half of every register uses the active edge, so NEG_TRIGGER
  // simply inverts the clock seen by the whole cell.
  assign clk_act = clk ^ NEG_TRIGGER;
  assign pin_in  = PACKAGE_PIN;
  assign in_ce   = CLOCK_ENABLE &
                   ~((PT.in_mode == PIN_INPUT_REG_LATCH) & LATCH_INPUT_VALUE);

  sb_io_ddr_reg u_in_reg (
    .clk_i    (clk_act),
    .rst_ni   (rst_n),
    .ce_i     (in_ce),
    .d_rise_i (pin_in),
    .d_fall_i (pin_in),
    .q_rise_o (in_q0),
    .q_fall_o (in_q1)
  );

  sb_io_ddr_reg u_out_reg (
    .clk_i    (clk_act),
    .rst_ni   (rst_n),
    .ce_i     (CLOCK_ENABLE),
    .d_rise_i (D_OUT_0),
    .d_fall_i (D_OUT_1),
    .q_rise_o (out_q0),
    .q_fall_o (out_q1)
  );

  always_ff @(posedge clk_act or negedge rst_n) begin
    if (!rst_n)            oe_q <= 1'b0;
    else if (CLOCK_ENABLE) oe_q <= OUTPUT_ENABLE;
  end

  // Transparent while LATCH_INPUT_VALUE is low; holds the pin level otherwise.
  always_latch begin
    if (!rst_n)                  lat_q <= 1'b0;
    else if (!LATCH_INPUT_VALUE) lat_q <= pin_in;
  end

  always_comb begin
    din0_d     = in_q0;
    out_data_d = D_OUT_0;
    oe_drive_d = 1'b0;

    case (PT.in_mode)
      PIN_INPUT:           din0_d = pin_in;
      PIN_INPUT_LATCH:     din0_d = lat_q;
      PIN_INPUT_REG,
      PIN_INPUT_REG_LATCH: din0_d = in_q0;
      default:             din0_d = in_q0;
    endcase

    case (PT.out_mode)
      OUT_SIMPLE:  out_data_d = D_OUT_0;
      OUT_REG:     out_data_d = out_q0;
      OUT_REG_INV: out_data_d = ~out_q0;
      OUT_DDR:     out_data_d = clk_act ? out_q0 : out_q1;
      default:     out_data_d = D_OUT_0;
    endcase

    case (PT.oe_mode)
      OE_OFF:     oe_drive_d = 1'b0;
      OE_ON:      oe_drive_d = 1'b1;
      OE_TRI:     oe_drive_d = OUTPUT_ENABLE;
      OE_TRI_REG: oe_drive_d = oe_q;
      default:    oe_drive_d = 1'b0;
    endcase
  end

  assign D_IN_0      = din0_d;
  assign D_IN_1      = in_q1;
  assign PACKAGE_PIN = oe_drive_d ? out_data_d : 1'bz;

  if (PULLUP) begin : g_pullup
    pullup u_pullup (PACKAGE_PIN);
  end

endmodule

// File: tb/tb_sb_io_cell.sv
// Scenario bench for sb_io_cell: several cells, each configured for one path.
module tb_sb_io_cell;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ce = 1'b1;

  // A: comb input + tristate simple output, pull-up (button configuration)
  logic drv_a_en = 1'b0, drv_a = 1'b0, oe_a = 1'b0, dout_a = 1'b0;
  wire  pin_a;
  logic din0_a, din1_a;
  assign pin_a = drv_a_en ? drv_a : 1'bz;

  // B: registered input, registered output, always driven
  logic dout_b = 1'b0;
  wire  pin_b;
  logic din0_b, din1_b;

  // C: DDR output, always driven
  logic dout_c0 = 1'b0, dout_c1 = 1'b0;
  wire  pin_c;
  logic din0_c, din1_c;

  // D: DDR input, never driven by the cell
  logic drv_d = 1'b0;
  wire  pin_d;
  logic din0_d, din1_d;
  assign pin_d = drv_d;

  // E: latched input, simple output with registered OE, pull-up
  logic dout_e = 1'b0, oe_e = 1'b0, latch_e = 1'b0;
  wire  pin_e;
  logic din0_e, din1_e;

  int tests  = 0;
  int failed = 0;
  bit pin_q[$];
  bit din_q[$];

  always #5 clk = ~clk;

  sb_io_cell #(.PIN_TYPE(6'b101001), .PULLUP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pin_a), .CLOCK_ENABLE(ce),
    .LATCH_INPUT_VALUE(1'b0), .OUTPUT_ENABLE(oe_a), .D_OUT_0(dout_a),
    .D_OUT_1(1'b0), .D_IN_0(din0_a), .D_IN_1(din1_a));

  sb_io_cell #(.PIN_TYPE(6'b010100), .PULLUP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pin_b), .CLOCK_ENABLE(ce),
    .LATCH_INPUT_VALUE(1'b0), .OUTPUT_ENABLE(1'b0), .D_OUT_0(dout_b),
    .D_OUT_1(1'b0), .D_IN_0(din0_b), .D_IN_1(din1_b));

  sb_io_cell #(.PIN_TYPE(6'b010000), .PULLUP(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pin_c), .CLOCK_ENABLE(ce),
    .LATCH_INPUT_VALUE(1'b0), .OUTPUT_ENABLE(1'b0), .D_OUT_0(dout_c0),
    .D_OUT_1(dout_c1), .D_IN_0(din0_c), .D_IN_1(din1_c));

  sb_io_cell #(.PIN_TYPE(6'b000000), .PULLUP(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pin_d), .CLOCK_ENABLE(ce),
    .LATCH_INPUT_VALUE(1'b0), .OUTPUT_ENABLE(1'b0), .D_OUT_0(1'b0),
    .D_OUT_1(1'b0), .D_IN_0(din0_d), .D_IN_1(din1_d));

  sb_io_cell #(.PIN_TYPE(6'b111011), .PULLUP(1'b1)) u_e (
    .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pin_e), .CLOCK_ENABLE(ce),
    .LATCH_INPUT_VALUE(latch_e), .OUTPUT_ENABLE(oe_e), .D_OUT_0(dout_e),
    .D_OUT_1(1'b0), .D_IN_0(din0_e), .D_IN_1(din1_e));

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests++; if (din0_b !== 1'b0) begin failed++; $display("FAIL reset_din0_b: got %b want 0", din0_b); end
    tests++; if (pin_b !== 1'b0) begin failed++; $display("FAIL reset_pin_b: got %b want 0", pin_b); end
    tests++; if (pin_c !== 1'b0) begin failed++; $display("FAIL reset_pin_c: got %b want 0", pin_c); end
    tests++; if (din0_d !== 1'b0) begin failed++; $display("FAIL reset_din0_d: got %b want 0", din0_d); end
    tests++; if (din1_d !== 1'b0) begin failed++; $display("FAIL reset_din1_d: got %b want 0", din1_d); end
    tests++; if (pin_e !== 1'b1) begin failed++; $display("FAIL reset_pin_e_released: got %b want 1", pin_e); end
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_comb_input();
    drv_a_en = 1'b0; oe_a = 1'b0;
    #1;
    tests++; if (din0_a !== 1'b1) begin failed++; $display("FAIL comb_pullup_din0: got %b want 1", din0_a); end
    tests++; if (pin_a !== 1'b1) begin failed++; $display("FAIL comb_pullup_pin: got %b want 1", pin_a); end
    drv_a = 1'b0; drv_a_en = 1'b1;
    #1;
    tests++; if (din0_a !== 1'b0) begin failed++; $display("FAIL comb_drive0: got %b want 0", din0_a); end
    drv_a = 1'b1;
    #1;
    tests++; if (din0_a !== 1'b1) begin failed++; $display("FAIL comb_drive1: got %b want 1", din0_a); end
    drv_a_en = 1'b0;
  endtask

  task automatic test_oe_tristate();
    drv_a_en = 1'b0; dout_a = 1'b0; oe_a = 1'b1;
    #1;
    tests++; if (pin_a !== 1'b0) begin failed++; $display("FAIL oe_on_pin: got %b want 0", pin_a); end
    tests++; if (din0_a !== 1'b0) begin failed++; $display("FAIL oe_on_din0: got %b want 0", din0_a); end
    oe_a = 1'b0;
    #1;
    tests++; if (pin_a !== 1'b1) begin failed++; $display("FAIL oe_off_pin: got %b want 1", pin_a); end
    tests++; if (din0_a !== 1'b1) begin failed++; $display("FAIL oe_off_din0: got %b want 1", din0_a); end
  endtask

  task automatic test_registered();
    @(negedge clk); #2 dout_b = 1'b1;
    #1;
    tests++; if (pin_b !== 1'b0) begin failed++; $display("FAIL reg_out_before_edge: got %b want 0", pin_b); end
    @(posedge clk); #1;
    tests++; if (pin_b !== 1'b1) begin failed++; $display("FAIL reg_out_after_edge: got %b want 1", pin_b); end
    tests++; if (din0_b !== 1'b0) begin failed++; $display("FAIL reg_in_first_edge: got %b want 0", din0_b); end
    @(posedge clk); #1;
    tests++; if (din0_b !== 1'b1) begin failed++; $display("FAIL reg_in_second_edge: got %b want 1", din0_b); end
  endtask

  task automatic test_back_to_back();
    bit b, exp_pin, exp_din;
    pin_q.delete(); din_q.delete();
    din_q.push_back(1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #2;
      b = 1'($urandom_range(0, 1));
      dout_b = b;
      pin_q.push_back(b);
      @(posedge clk); #1;
      exp_din = din_q.pop_front();
      tests++; if (din0_b !== exp_din) begin failed++; $display("FAIL b2b_din0[%0d]: got %b want %b", i, din0_b, exp_din); end
      exp_pin = pin_q.pop_front();
      tests++; if (pin_b !== exp_pin) begin failed++; $display("FAIL b2b_pin[%0d]: got %b want %b", i, pin_b, exp_pin); end
      din_q.push_back(exp_pin);
    end
    @(posedge clk); #1;
    exp_din = din_q.pop_front();
    tests++; if (din0_b !== exp_din) begin failed++; $display("FAIL b2b_din0_drain: got %b want %b", din0_b, exp_din); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); #2 dout_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (din0_b !== 1'b1) begin failed++; $display("FAIL arst_pre_din0: got %b want 1", din0_b); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    tests++; if (din0_b !== 1'b0) begin failed++; $display("FAIL arst_din0: got %b want 0", din0_b); end
    tests++; if (pin_b !== 1'b0) begin failed++; $display("FAIL arst_out_reg0: got %b want 0", pin_b); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (pin_b !== 1'b1) begin failed++; $display("FAIL arst_recover_pin: got %b want 1", pin_b); end
    tests++; if (din0_b !== 1'b0) begin failed++; $display("FAIL arst_recover_din0_1: got %b want 0", din0_b); end
    @(posedge clk); #1;
    tests++; if (din0_b !== 1'b1) begin failed++; $display("FAIL arst_recover_din0_2: got %b want 1", din0_b); end
  endtask

  task automatic test_clock_enable();
    @(negedge clk); #2 drv_d = 1'b1;
    @(posedge clk); #1;
    tests++; if (din0_d !== 1'b1) begin failed++; $display("FAIL ce_pre: got %b want 1", din0_d); end
    #1 ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2 drv_d = ~drv_d;
      @(posedge clk); #1;
      tests++; if (din0_d !== 1'b1) begin failed++; $display("FAIL ce_hold[%0d]: got %b want 1", i, din0_d); end
    end
    #1 ce = 1'b1;
    @(posedge clk); #1;
    tests++; if (din0_d !== 1'b0) begin failed++; $display("FAIL ce_resume: got %b want 0", din0_d); end
  endtask

  task automatic test_ddr_in();
    @(negedge clk); #2 drv_d = 1'b1;
    @(posedge clk); #2 drv_d = 1'b0;
    @(negedge clk); #1;
    tests++; if (din0_d !== 1'b1) begin failed++; $display("FAIL ddr_in_rise_a: got %b want 1", din0_d); end
    tests++; if (din1_d !== 1'b0) begin failed++; $display("FAIL ddr_in_fall_a: got %b want 0", din1_d); end
    #1 drv_d = 1'b0;
    @(posedge clk); #2 drv_d = 1'b1;
    @(negedge clk); #1;
    tests++; if (din0_d !== 1'b0) begin failed++; $display("FAIL ddr_in_rise_b: got %b want 0", din0_d); end
    tests++; if (din1_d !== 1'b1) begin failed++; $display("FAIL ddr_in_fall_b: got %b want 1", din1_d); end
  endtask

  task automatic test_ddr_out();
    @(negedge clk); #2 dout_c0 = 1'b1; dout_c1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++; if (pin_c !== 1'b1) begin failed++; $display("FAIL ddr_out_high[%0d]: got %b want 1", i, pin_c); end
      @(negedge clk); #1;
      tests++; if (pin_c !== 1'b0) begin failed++; $display("FAIL ddr_out_low[%0d]: got %b want 0", i, pin_c); end
    end
    #1 dout_c0 = 1'b0; dout_c1 = 1'b1;
    @(posedge clk); #1;
    tests++; if (pin_c !== 1'b0) begin failed++; $display("FAIL ddr_out_swap_high: got %b want 0", pin_c); end
    @(negedge clk); #1;
    tests++; if (pin_c !== 1'b1) begin failed++; $display("FAIL ddr_out_swap_low: got %b want 1", pin_c); end
  endtask

  task automatic test_latch_oe_reg();
    @(negedge clk); #2 dout_e = 1'b0; oe_e = 1'b1;
    #1;
    tests++; if (pin_e !== 1'b1) begin failed++; $display("FAIL oereg_before_edge: got %b want 1", pin_e); end
    @(posedge clk); #1;
    tests++; if (pin_e !== 1'b0) begin failed++; $display("FAIL oereg_after_edge: got %b want 0", pin_e); end
    tests++; if (din0_e !== 1'b0) begin failed++; $display("FAIL latch_transparent: got %b want 0", din0_e); end
    latch_e = 1'b1;
    #1 dout_e = 1'b1;
    #1;
    tests++; if (pin_e !== 1'b1) begin failed++; $display("FAIL latch_pin_moves: got %b want 1", pin_e); end
    tests++; if (din0_e !== 1'b0) begin failed++; $display("FAIL latch_hold: got %b want 0", din0_e); end
    latch_e = 1'b0;
    #1;
    tests++; if (din0_e !== 1'b1) begin failed++; $display("FAIL latch_release: got %b want 1", din0_e); end
    @(negedge clk); #2 oe_e = 1'b0; dout_e = 1'b0;
    #1;
    tests++; if (pin_e !== 1'b0) begin failed++; $display("FAIL oereg_still_driving: got %b want 0", pin_e); end
    @(posedge clk); #1;
    tests++; if (pin_e !== 1'b1) begin failed++; $display("FAIL oereg_released: got %b want 1", pin_e); end
  endtask

  initial begin
    test_reset();
    test_comb_input();
    test_oe_tristate();
    test_registered();
    test_back_to_back();
    test_async_reset();
    test_clock_enable();
    test_ddr_in();
    test_ddr_out();
    test_latch_oe_reg();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", failed);
    $fatal(1, "timeout");
  end

endmodule
